// File: rtl/coin_escrow_unit.sv
// Coin escrow: validates coins, holds credit, deducts PRICE on vend, refunds credit through a unit-coin hopper.
// Optional hopper timeout with sticky fault flag is enabled by defining COIN_HOPPER_TIMEOUT_EN.
module coin_escrow_unit #(
    parameter int CREDIT_W   = 8,
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 20,
    parameter int DISP_GAP   = 2,
    parameter int HOPPER_TMO = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_pulse,
    input  logic [1:0]          coin_denom,
    input  logic                product_make,
    input  logic                coin_out,
    input  logic                hopper_ack,
    output logic                coin,
    output logic [CREDIT_W-1:0] coin_val,
    output logic                coin_reject,
    output logic                vend_done,
    output logic                hopper_req,
    output logic                hopper_fault
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PAYOUT,
        GAP
    } state_t;

    // One counter serves both the inter-payout gap and the hopper timeout.
    localparam int CNT_MAX = (DISP_GAP > HOPPER_TMO) ? DISP_GAP : HOPPER_TMO;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                pm_q;
    logic                coin_q, coin_d;
    logic                coin_reject_q, coin_reject_d;
    logic                vend_done_q, vend_done_d;
    logic                hopper_req_q, hopper_req_d;

    logic                pm_rise;
    logic [CREDIT_W-1:0] coin_value;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic                refund_go;
    logic                vend_go;
    logic                pay_ack;
    logic                gap_done;
    logic                tmo_hit;

    always_comb begin
        coin_value = '0;
        case (coin_denom)
            2'b00:   coin_value = CREDIT_W'(1);
            2'b01:   coin_value = CREDIT_W'(2);
            2'b10:   coin_value = CREDIT_W'(5);
            default: coin_value = '0;
        endcase
    end

    assign pm_rise   = product_make & ~pm_q;
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_value};
    assign coin_ok   = coin_pulse && (coin_denom != 2'b11)
                       && ((state_q == IDLE) || (state_q == COLLECT))
                       && !pm_rise && !coin_out
                       && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign refund_go = (state_q == COLLECT) && coin_out && (credit_q != '0);
    assign vend_go   = (state_q == COLLECT) && pm_rise && !refund_go
                       && (credit_q >= CREDIT_W'(PRICE));
    assign pay_ack   = (state_q == PAYOUT) && hopper_ack;
    assign gap_done  = (state_q == GAP) && (wait_cnt_q == CNT_W'(DISP_GAP - 1));

`ifdef COIN_HOPPER_TIMEOUT_EN
    logic hopper_fault_q, hopper_fault_d;

    assign tmo_hit      = (state_q == PAYOUT) && !hopper_ack
                          && (wait_cnt_q == CNT_W'(HOPPER_TMO - 1));
    assign hopper_fault_d = hopper_fault_q | tmo_hit;
    assign hopper_fault   = hopper_fault_q;

    always_ff @(posedge clk) begin
        if (reset) hopper_fault_q <= 1'b0;
        else       hopper_fault_q <= hopper_fault_d;
    end
`else
    assign tmo_hit      = 1'b0;
    assign hopper_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            wait_cnt_q    <= '0;
            pm_q          <= 1'b0;
            coin_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            vend_done_q   <= 1'b0;
            hopper_req_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            wait_cnt_q    <= wait_cnt_d;
            pm_q          <= product_make;
            coin_q        <= coin_d;
            coin_reject_q <= coin_reject_d;
            vend_done_q   <= vend_done_d;
            hopper_req_q  <= hopper_req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (coin_ok) state_d = COLLECT;
            end
            COLLECT: begin
                if (refund_go)                          state_d = PAYOUT;
                else if (vend_go && (credit_q == CREDIT_W'(PRICE))) state_d = IDLE;
            end
            PAYOUT: begin
                if (pay_ack)      state_d = GAP;
                else if (tmo_hit) state_d = COLLECT;
            end
            GAP: begin
                if (gap_done) state_d = (credit_q != '0) ? PAYOUT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        credit_d = credit_q;
        if (coin_ok)      credit_d = coin_sum[CREDIT_W-1:0];
        else if (vend_go) credit_d = credit_q - CREDIT_W'(PRICE);
        else if (pay_ack) credit_d = credit_q - CREDIT_W'(1);

        if ((state_d != state_q) || (state_q == IDLE) || (state_q == COLLECT))
            wait_cnt_d = '0;
        else
            wait_cnt_d = wait_cnt_q + CNT_W'(1);

        coin_d        = (credit_d != '0);
        coin_reject_d = coin_pulse && !coin_ok;
        vend_done_d   = vend_go;
        hopper_req_d  = (state_d == PAYOUT);
    end

    assign coin        = coin_q;
    assign coin_val    = credit_q;
    assign coin_reject = coin_reject_q;
    assign vend_done   = vend_done_q;
    assign hopper_req  = hopper_req_q;

endmodule

// File: tb/tb_coin_escrow_unit.sv
// Directed self-checking bench for coin_escrow_unit (default parameters).
// The hopper timeout section runs only when COIN_HOPPER_TIMEOUT_EN is defined.
module tb_coin_escrow_unit;

    localparam int DISP_GAP = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_pulse;
    logic [1:0] coin_denom;
    logic       product_make;
    logic       coin_out;
    logic       hopper_ack;
    logic       coin;
    logic [7:0] coin_val;
    logic       coin_reject;
    logic       vend_done;
    logic       hopper_req;
    logic       hopper_fault;

    int n_checks = 0;
    int n_fail   = 0;

    coin_escrow_unit #(
        .CREDIT_W  (8),
        .PRICE     (3),
        .MAX_CREDIT(20),
        .DISP_GAP  (DISP_GAP),
        .HOPPER_TMO(64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_pulse  (coin_pulse),
        .coin_denom  (coin_denom),
        .product_make(product_make),
        .coin_out    (coin_out),
        .hopper_ack  (hopper_ack),
        .coin        (coin),
        .coin_val    (coin_val),
        .coin_reject (coin_reject),
        .vend_done   (vend_done),
        .hopper_req  (hopper_req),
        .hopper_fault(hopper_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic insert(input logic [1:0] d);
        coin_pulse = 1'b1;
        coin_denom = d;
        step();
        coin_pulse = 1'b0;
        coin_denom = 2'b00;
    endtask

    initial begin
        int vends;
        int cnt;
        reset        = 1'b1;
        coin_pulse   = 1'b0;
        coin_denom   = 2'b00;
        product_make = 1'b0;
        coin_out     = 1'b0;
        hopper_ack   = 1'b0;
        step();
        step();
        check("rst_coin_val", int'(coin_val), 0);
        check("rst_coin", int'(coin), 0);
        check("rst_hopper_req", int'(hopper_req), 0);
        check("rst_outputs", int'({coin_reject, vend_done, hopper_fault}), 0);
        reset = 1'b0;
        step();

        // coins 2 and 5
        insert(2'b01);
        check("coin2_val", int'(coin_val), 2);
        check("coin2_coin", int'(coin), 1);
        check("coin2_reject", int'(coin_reject), 0);
        insert(2'b10);
        check("coin5_val", int'(coin_val), 7);
        check("coin5_reject", int'(coin_reject), 0);

        // held product_make vends once
        product_make = 1'b1;
        vends = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            vends += int'(vend_done);
        end
        check("vend_once", vends, 1);
        check("vend_val", int'(coin_val), 4);
        product_make = 1'b0;
        step();

        // refund of 4 units, coin_out dropped after the first payout starts
        coin_out = 1'b1;
        step();
        check("refund_req", int'(hopper_req), 1);
        coin_out = 1'b0;
        for (int p = 0; p < 4; p++) begin
            cnt = 0;
            while (!hopper_req && cnt < 20) begin
                step();
                cnt++;
            end
            if (p > 0) check("gap_len", cnt, DISP_GAP);
            check("pay_val_before", int'(coin_val), 4 - p);
            step();
            check("req_held", int'(hopper_req), 1);
            hopper_ack = 1'b1;
            step();
            hopper_ack = 1'b0;
            check("req_drop", int'(hopper_req), 0);
            check("pay_val_after", int'(coin_val), 3 - p);
        end
        for (int i = 0; i < 4; i++) step();
        check("refund_done_coin", int'(coin), 0);
        check("refund_done_req", int'(hopper_req), 0);
        coin_out = 1'b1;
        step();
        step();
        check("idle_coin_out_ignored", int'(hopper_req), 0);
        coin_out = 1'b0;
        step();

        // ceiling
        insert(2'b10);
        insert(2'b10);
        insert(2'b10);
        insert(2'b01);
        insert(2'b00);
        check("credit18", int'(coin_val), 18);
        insert(2'b10);
        check("over_reject", int'(coin_reject), 1);
        check("over_val", int'(coin_val), 18);
        insert(2'b01);
        check("exact_max_reject", int'(coin_reject), 0);
        check("exact_max_val", int'(coin_val), 20);
        insert(2'b00);
        check("max_plus1_reject", int'(coin_reject), 1);
        check("max_plus1_val", int'(coin_val), 20);
        reset = 1'b1;
        step();
        reset = 1'b0;
        insert(2'b11);
        check("invalid_reject", int'(coin_reject), 1);
        check("invalid_val", int'(coin_val), 0);
        step();
        check("reject_one_cycle", int'(coin_reject), 0);

        // short credit vend ignored; coin coinciding with a vend edge rejected
        insert(2'b01);
        product_make = 1'b1;
        step();
        check("short_vend", int'(vend_done), 0);
        check("short_vend_val", int'(coin_val), 2);
        product_make = 1'b0;
        step();
        product_make = 1'b1;
        insert(2'b01);
        check("coin_vs_vend_reject", int'(coin_reject), 1);
        check("coin_vs_vend_val", int'(coin_val), 2);
        product_make = 1'b0;
        step();
        insert(2'b01);
        check("credit4", int'(coin_val), 4);

        // refund wins over vend edge; coin in PAYOUT rejected; reset mid-payout
        product_make = 1'b1;
        coin_out     = 1'b1;
        step();
        check("prio_no_vend", int'(vend_done), 0);
        check("prio_req", int'(hopper_req), 1);
        check("prio_val", int'(coin_val), 4);
        product_make = 1'b0;
        coin_out     = 1'b0;
        insert(2'b00);
        check("payout_reject", int'(coin_reject), 1);
        check("payout_val", int'(coin_val), 4);
        check("payout_req_kept", int'(hopper_req), 1);
        reset = 1'b1;
        step();
        check("rst_mid_req", int'(hopper_req), 0);
        check("rst_mid_val", int'(coin_val), 0);
        reset = 1'b0;
        step();

        insert(2'b10);
        coin_out = 1'b1;
        step();
        coin_out = 1'b0;
        check("stall_req", int'(hopper_req), 1);
`ifdef COIN_HOPPER_TIMEOUT_EN
        cnt = 0;
        while (hopper_req && cnt < 200) begin
            step();
            cnt++;
        end
        check("tmo_cycles", cnt, 64);
        check("tmo_fault", int'(hopper_fault), 1);
        check("tmo_val", int'(coin_val), 5);
        coin_out = 1'b1;
        step();
        coin_out = 1'b0;
        check("retry_req", int'(hopper_req), 1);
        hopper_ack = 1'b1;
        step();
        hopper_ack = 1'b0;
        check("retry_val", int'(coin_val), 4);
        check("fault_sticky", int'(hopper_fault), 1);
`else
        for (int i = 0; i < 80; i++) step();
        check("no_tmo_req", int'(hopper_req), 1);
        check("no_tmo_fault", int'(hopper_fault), 0);
        check("no_tmo_val", int'(coin_val), 5);
`endif
        reset = 1'b1;
        step();
        check("final_rst_fault", int'(hopper_fault), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
